// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the load/store unit.
//   mem_op_e    - access size/sign encoding (funct3-style); codes 3, 6 and 7 are unused
//   lsu_err_e   - response status returned with every LSU response
//   lsu_state_e - sequencer states of lsu_ctrl
//   lsu_misaligned() - alignment check; unknown ops are checked as a word access
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MEM_BYTE   = 3'b000,
    MEM_HALF   = 3'b001,
    MEM_WORD   = 3'b010,
    MEM_BYTE_U = 3'b100,
    MEM_HALF_U = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_OK       = 2'd0,
    LSU_MISALIGN = 2'd1,
    LSU_TIMEOUT  = 2'd2
  } lsu_err_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

  function automatic logic lsu_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    logic mis;
    case (op)
      MEM_BYTE, MEM_BYTE_U: mis = 1'b0;
      MEM_HALF, MEM_HALF_U: mis = addr_lo[0];
      default:              mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// lsu_store_align: store lane steering for the data-memory port (purely combinational).
//   i_op      - access op; _U ops store exactly like the signed ops, unknown ops as a word
//   i_addr_lo - byte offset within the word
//   i_wdata   - right-justified store data
//   o_be      - byte enables
//   o_wdata   - store data replicated across all lanes of its size
module lsu_store_align
  import riscv_pkg::*;
(
  input  mem_op_e               i_op,
  input  logic [1:0]            i_addr_lo,
  input  logic [XLEN-1:0]       i_wdata,
  output logic [3:0]            o_be,
  output logic [XLEN-1:0]       o_wdata
);

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_op)
      MEM_BYTE, MEM_BYTE_U: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      MEM_HALF, MEM_HALF_U: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the MEM stage and the data-memory port.
//   Pipeline side : i_req_valid/o_req_ready handshake, i_req_we/op/addr/wdata request fields,
//                   o_rsp_valid pulse with o_rsp_rdata/o_rsp_err, o_mem_busy stall.
//   Memory side   : o_dmem_req/i_dmem_gnt request, o_dmem_we/be/addr/wdata,
//                   i_dmem_rvalid/i_dmem_rdata response.
//   One access in flight; misaligned accesses answer without touching memory; a response
//   timeout in WAIT marks the next rvalid as stale so it is dropped when it finally shows up.
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  mem_op_e           i_req_op,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output lsu_err_e          o_rsp_err,
  output logic              o_mem_busy,
  output logic              o_dmem_req,
  input  logic              i_dmem_gnt,
  output logic              o_dmem_we,
  output logic [3:0]        o_dmem_be,
  output logic [XLEN-1:0]   o_dmem_addr,
  output logic [XLEN-1:0]   o_dmem_wdata,
  input  logic              i_dmem_rvalid,
  input  logic [XLEN-1:0]   i_dmem_rdata
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic              r_stale;
  logic [CntW-1:0]   r_cnt;
  logic              r_we;
  mem_op_e           r_op;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  lsu_err_e          r_err;

  logic              w_accept;
  logic              w_misalign;
  logic              w_rvalid;
  logic              w_timeout;
  logic              w_in_req;
  logic [3:0]        w_st_be;
  logic [XLEN-1:0]   w_st_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load_data;

  assign w_accept   = i_req_valid && o_req_ready;
  assign w_misalign = lsu_misaligned(i_req_op, i_req_addr[1:0]);
  // A stale rvalid belongs to a timed-out access and never counts as a response.
  assign w_rvalid   = i_dmem_rvalid && !r_stale;
  assign w_timeout  = (r_state == LSU_WAIT) && !w_rvalid && (r_cnt == CntMax);
  assign w_in_req   = (r_state == LSU_REQ);

  lsu_store_align u_store_align (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .o_be      (w_st_be),
    .o_wdata   (w_st_wdata)
  );

  // Load lane extraction and extension from the raw memory word.
  always_comb begin
    w_byte = i_dmem_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = i_dmem_rdata[7:0];
      2'd1: w_byte = i_dmem_rdata[15:8];
      2'd2: w_byte = i_dmem_rdata[23:16];
      2'd3: w_byte = i_dmem_rdata[31:24];
      default: ;
    endcase
    w_half = r_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (r_op)
      MEM_BYTE:   w_load_data = {{24{w_byte[7]}}, w_byte};
      MEM_BYTE_U: w_load_data = {24'd0, w_byte};
      MEM_HALF:   w_load_data = {{16{w_half[15]}}, w_half};
      MEM_HALF_U: w_load_data = {16'd0, w_half};
      default:    w_load_data = i_dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept) w_state_nxt = w_misalign ? LSU_RESP : LSU_REQ;
      end
      LSU_REQ: begin
        if (i_dmem_gnt) w_state_nxt = LSU_WAIT;
      end
      LSU_WAIT: begin
        if (w_rvalid || w_timeout) w_state_nxt = LSU_RESP;
      end
      LSU_RESP: w_state_nxt = LSU_IDLE;
      default:  w_state_nxt = LSU_IDLE;
    endcase
  end

  // Memory-side outputs are only driven while requesting, so they idle at zero.
  always_comb begin
    o_req_ready  = (r_state == LSU_IDLE);
    o_rsp_valid  = (r_state == LSU_RESP);
    o_mem_busy   = (r_state != LSU_IDLE);
    o_rsp_rdata  = r_rdata;
    o_rsp_err    = r_err;
    o_dmem_req   = w_in_req;
    o_dmem_we    = w_in_req && r_we;
    o_dmem_be    = 4'b0000;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    if (w_in_req) begin
      o_dmem_be   = r_we ? w_st_be : 4'b1111;
      o_dmem_addr = {r_addr[XLEN-1:2], 2'b00};
      if (r_we) o_dmem_wdata = w_st_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= LSU_IDLE;
      r_stale <= 1'b0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_op    <= MEM_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= LSU_OK;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_we    <= i_req_we;
        r_op    <= i_req_op;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_rdata <= '0;
        r_err   <= w_misalign ? LSU_MISALIGN : LSU_OK;
      end

      // Counter runs only while staying in WAIT, so every WAIT entry starts from zero.
      if ((r_state == LSU_WAIT) && (w_state_nxt == LSU_WAIT)) r_cnt <= r_cnt + 1'b1;
      else                                                     r_cnt <= '0;

      if ((r_state == LSU_WAIT) && w_rvalid && !r_we) r_rdata <= w_load_data;

      if (w_timeout) begin
        r_err   <= LSU_TIMEOUT;
        r_stale <= 1'b1;
      end else if (r_stale && i_dmem_rvalid) begin
        r_stale <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl.
module tb_lsu_ctrl;
  import riscv_pkg::*;

  localparam int unsigned TO = 64;

  logic            i_clk;
  logic            i_rst_n;
  logic            i_req_valid;
  logic            o_req_ready;
  logic            i_req_we;
  mem_op_e         i_req_op;
  logic [31:0]     i_req_addr;
  logic [31:0]     i_req_wdata;
  logic            o_rsp_valid;
  logic [31:0]     o_rsp_rdata;
  lsu_err_e        o_rsp_err;
  logic            o_mem_busy;
  logic            o_dmem_req;
  logic            i_dmem_gnt;
  logic            o_dmem_we;
  logic [3:0]      o_dmem_be;
  logic [31:0]     o_dmem_addr;
  logic [31:0]     o_dmem_wdata;
  logic            i_dmem_rvalid;
  logic [31:0]     i_dmem_rdata;

  int n_checks;
  int n_errors;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_we      (i_req_we),
    .i_req_op      (i_req_op),
    .i_req_addr    (i_req_addr),
    .i_req_wdata   (i_req_wdata),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .o_mem_busy    (o_mem_busy),
    .o_dmem_req    (o_dmem_req),
    .i_dmem_gnt    (i_dmem_gnt),
    .o_dmem_we     (o_dmem_we),
    .o_dmem_be     (o_dmem_be),
    .o_dmem_addr   (o_dmem_addr),
    .o_dmem_wdata  (o_dmem_wdata),
    .i_dmem_rvalid (i_dmem_rvalid),
    .i_dmem_rdata  (i_dmem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present a request for one cycle; returns in cycle T+1 after the accept edge.
  task automatic issue(input logic we, input mem_op_e op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_op    = op;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    step();
    i_req_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rsp_valid_low"}, 32'(o_rsp_valid), 32'd0);
    check({tag, "_ready_back"},    32'(o_req_ready), 32'd1);
    check({tag, "_busy_low"},      32'(o_mem_busy),  32'd0);
  endtask

  // Full access: gnt after gnt_wait extra REQ cycles, rvalid the cycle after gnt.
  task automatic run_access(input string tag, input logic we, input mem_op_e op,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int gnt_wait,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
    issue(we, op, addr, wdata);
    check({tag, "_req"},   32'(o_dmem_req),  32'd1);
    check({tag, "_ready"}, 32'(o_req_ready), 32'd0);
    check({tag, "_busy"},  32'(o_mem_busy),  32'd1);
    check({tag, "_we"},    32'(o_dmem_we),   32'(we));
    check({tag, "_be"},    32'(o_dmem_be),   32'(exp_be));
    check({tag, "_addr"},  o_dmem_addr,      {addr[31:2], 2'b00});
    if (we) check({tag, "_wdata"}, o_dmem_wdata, exp_wdata);
    for (int i = 0; i < gnt_wait; i++) begin
      step();
      check({tag, "_req_held"},   32'(o_dmem_req),  32'd1);
      check({tag, "_be_held"},    32'(o_dmem_be),   32'(exp_be));
      check({tag, "_addr_held"},  o_dmem_addr,      {addr[31:2], 2'b00});
      if (we) check({tag, "_wdata_held"}, o_dmem_wdata, exp_wdata);
    end
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    check({tag, "_req_drop"}, 32'(o_dmem_req), 32'd0);
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = rdata;
    step();
    i_dmem_rvalid = 1'b0;
    check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
    check({tag, "_rdata"},     o_rsp_rdata,      exp_rdata);
    check({tag, "_err"},       32'(o_rsp_err),   32'(LSU_OK));
    check({tag, "_rsp_busy"},  32'(o_mem_busy),  32'd1);
    step();
    check_idle(tag);
  endtask

  task automatic run_misalign(input string tag, input logic we, input mem_op_e op,
                              input logic [31:0] addr);
    issue(we, op, addr, 32'h5555_5555);
    check({tag, "_no_req"},    32'(o_dmem_req),  32'd0);
    check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
    check({tag, "_err"},       32'(o_rsp_err),   32'(LSU_MISALIGN));
    check({tag, "_rdata"},     o_rsp_rdata,      32'd0);
    step();
    check({tag, "_no_req2"}, 32'(o_dmem_req), 32'd0);
    check_idle(tag);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    i_rst_n       = 1'b0;
    i_req_valid   = 1'b0;
    i_req_we      = 1'b0;
    i_req_op      = MEM_WORD;
    i_req_addr    = '0;
    i_req_wdata   = '0;
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata  = '0;
    repeat (2) step();

    check("rst_ready",     32'(o_req_ready),  32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid),  32'd0);
    check("rst_rdata",     o_rsp_rdata,       32'd0);
    check("rst_err",       32'(o_rsp_err),    32'(LSU_OK));
    check("rst_busy",      32'(o_mem_busy),   32'd0);
    check("rst_dmem_req",  32'(o_dmem_req),   32'd0);
    check("rst_dmem_we",   32'(o_dmem_we),    32'd0);
    check("rst_dmem_be",   32'(o_dmem_be),    32'd0);
    check("rst_dmem_addr", o_dmem_addr,       32'd0);
    check("rst_dmem_wd",   o_dmem_wdata,      32'd0);
    i_rst_n = 1'b1;
    step();

    // Loads
    run_access("lw100",  1'b0, MEM_WORD,   32'h100, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0,
               32'hDEAD_BEEF);
    run_access("lb103",  1'b0, MEM_BYTE,   32'h103, 32'h0, 32'h80FF_1234, 0, 4'b1111, 32'h0,
               32'hFFFF_FF80);
    run_access("lbu103", 1'b0, MEM_BYTE_U, 32'h103, 32'h0, 32'h80FF_1234, 0, 4'b1111, 32'h0,
               32'h0000_0080);
    run_access("lb101",  1'b0, MEM_BYTE,   32'h101, 32'h0, 32'h80FF_1234, 0, 4'b1111, 32'h0,
               32'h0000_0012);
    run_access("lh102",  1'b0, MEM_HALF,   32'h102, 32'h0, 32'h8001_7FFF, 0, 4'b1111, 32'h0,
               32'hFFFF_8001);
    run_access("lhu102", 1'b0, MEM_HALF_U, 32'h102, 32'h0, 32'h8001_7FFF, 0, 4'b1111, 32'h0,
               32'h0000_8001);
    run_access("lh100",  1'b0, MEM_HALF,   32'h100, 32'h0, 32'h8001_7FFF, 1, 4'b1111, 32'h0,
               32'h0000_7FFF);
    run_access("lunk",   1'b0, mem_op_e'(3'b011), 32'h200, 32'h0, 32'hCAFE_F00D, 0, 4'b1111,
               32'h0, 32'hCAFE_F00D);

    // Stores
    run_access("sb101",  1'b1, MEM_BYTE,   32'h101, 32'h0000_00AB, 32'h0, 3, 4'b0010,
               32'hABAB_ABAB, 32'h0);
    run_access("sbu103", 1'b1, MEM_BYTE_U, 32'h103, 32'h1234_5677, 32'h0, 0, 4'b1000,
               32'h7777_7777, 32'h0);
    run_access("sh102",  1'b1, MEM_HALF,   32'h102, 32'h1234_CDEF, 32'h0, 1, 4'b1100,
               32'hCDEF_CDEF, 32'h0);
    run_access("shu100", 1'b1, MEM_HALF_U, 32'h100, 32'h0000_BEEF, 32'h0, 0, 4'b0011,
               32'hBEEF_BEEF, 32'h0);
    run_access("sw104",  1'b1, MEM_WORD,   32'h104, 32'h1234_5678, 32'h0, 0, 4'b1111,
               32'h1234_5678, 32'h0);

    // Misaligned
    run_misalign("lw102",   1'b0, MEM_WORD, 32'h102);
    run_misalign("sh003",   1'b1, MEM_HALF, 32'h003);
    run_misalign("lunk201", 1'b0, mem_op_e'(3'b111), 32'h201);

    // Timeout: WAIT lasts TO cycles, response follows
    issue(1'b0, MEM_WORD, 32'h300, 32'h0);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    repeat (TO - 1) step();
    check("to_not_yet", 32'(o_rsp_valid), 32'd0);
    check("to_busy",    32'(o_mem_busy),  32'd1);
    step();
    check("to_rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("to_err",       32'(o_rsp_err),   32'(LSU_TIMEOUT));
    check("to_rdata",     o_rsp_rdata,      32'd0);
    step();
    check_idle("to");

    // Late rvalid of the timed-out access arrives while the next load waits: dropped.
    issue(1'b0, MEM_WORD, 32'h104, 32'h0);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'hBAD0_BAD0;
    step();
    check("stale_dropped", 32'(o_rsp_valid), 32'd0);
    i_dmem_rdata = 32'h1122_3344;
    step();
    i_dmem_rvalid = 1'b0;
    check("stale_next_valid", 32'(o_rsp_valid), 32'd1);
    check("stale_next_rdata", o_rsp_rdata,      32'h1122_3344);
    check("stale_next_err",   32'(o_rsp_err),   32'(LSU_OK));
    step();
    check_idle("stale_next");
    run_access("after_stale", 1'b0, MEM_WORD, 32'h108, 32'h0, 32'h0BAD_F00D, 0, 4'b1111,
               32'h0, 32'h0BAD_F00D);

    // Reset while in WAIT
    issue(1'b0, MEM_WORD, 32'h400, 32'h0);
    i_dmem_gnt = 1'b1;
    step();
    i_dmem_gnt = 1'b0;
    step();
    check("wait_busy", 32'(o_mem_busy), 32'd1);
    i_rst_n = 1'b0;
    step();
    check("rstw_dmem_req",  32'(o_dmem_req),  32'd0);
    check("rstw_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rstw_ready",     32'(o_req_ready), 32'd1);
    check("rstw_busy",      32'(o_mem_busy),  32'd0);
    check("rstw_be",        32'(o_dmem_be),   32'd0);
    check("rstw_err",       32'(o_rsp_err),   32'(LSU_OK));
    i_rst_n = 1'b1;
    step();
    run_access("after_rst", 1'b0, MEM_BYTE_U, 32'h402, 32'h0, 32'hA5C3_0000, 0, 4'b1111,
               32'h0, 32'h0000_00C3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
